// File: rtl/conv2d_pkg.sv
// Shared definitions for the conv2d kernel scheduler and the layer that instantiates it.
package conv2d_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_START = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_OUT   = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_LOAD  = ST_LOAD,
        S_START = ST_START,
        S_WAIT  = ST_WAIT,
        S_OUT   = ST_OUT,
        S_DONE  = ST_DONE
    } sched_state_e;

    // A single-kernel job still needs a one-bit index.
    function automatic int kidx_width(input int kernel_total);
        if (kernel_total <= 1) begin
            return 1;
        end else begin
            return $clog2(kernel_total);
        end
    endfunction

    function automatic int result_width(input int bitwidth, input int double_scale, input int fmap_num);
        return bitwidth * (double_scale + 1) * fmap_num;
    endfunction

endpackage

// File: rtl/conv2d_kernel_sched.sv
// Runs a multi-kernel job through a single-kernel conv2d_feature datapath,
// fetching weights per kernel and handing each channel result downstream.
module conv2d_kernel_sched
    import conv2d_pkg::*;
#(
    parameter int BITWIDTH                 = 8,
    parameter int IS_BITWIDTH_DOUBLE_SCALE = 1,
    parameter int FEATURE_MAP_NUM          = 9,
    parameter int KERNEL_SIZE              = 9,
    parameter int KERNEL_TOTAL             = 4,
    localparam int KW = kidx_width(KERNEL_TOTAL),
    localparam int RW = result_width(BITWIDTH, IS_BITWIDTH_DOUBLE_SCALE, FEATURE_MAP_NUM),
    localparam int FW = FEATURE_MAP_NUM * KERNEL_SIZE * BITWIDTH,
    localparam int WW = KERNEL_SIZE * BITWIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [FW-1:0] cmd_fmaps,
    input  logic          abort,
    output logic          w_rd_en,
    output logic [KW-1:0] w_addr,
    input  logic [WW-1:0] w_rdata,
    output logic [FW-1:0] feature_maps,
    output logic [WW-1:0] weights,
    output logic          calculate_start,
    input  logic          calculate_done,
    input  logic [RW-1:0] channel_out,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic [KW-1:0] res_kidx,
    output logic          busy,
    output logic          job_done
);

    localparam logic [KW-1:0] K_LAST = KW'(KERNEL_TOTAL - 1);

    sched_state_e  state_r;
    logic [KW-1:0] k_r;
    logic [KW-1:0] k_inc_s;

    assign k_inc_s = k_r + KW'(1);

    // Job sequencer; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_IDLE;
            k_r             <= '0;
            cmd_ready       <= 1'b1;
            busy            <= 1'b0;
            w_rd_en         <= 1'b0;
            w_addr          <= '0;
            feature_maps    <= '0;
            weights         <= '0;
            calculate_start <= 1'b0;
            res_valid       <= 1'b0;
            res_data        <= '0;
            res_kidx        <= '0;
            job_done        <= 1'b0;
        end else begin
            w_rd_en         <= 1'b0;
            calculate_start <= 1'b0;
            job_done        <= 1'b0;
            if (abort) begin
                state_r   <= S_IDLE;
                k_r       <= '0;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            feature_maps <= cmd_fmaps;
                            k_r          <= '0;
                            w_addr       <= '0;
                            w_rd_en      <= 1'b1;
                            cmd_ready    <= 1'b0;
                            busy         <= 1'b1;
                            state_r      <= S_FETCH;
                        end else begin
                            state_r <= S_IDLE;
                        end
                    end
                    S_FETCH: begin
                        state_r <= S_LOAD;
                    end
                    // The RAM word for the strobe issued in FETCH is on w_rdata now.
                    S_LOAD: begin
                        weights         <= w_rdata;
                        calculate_start <= 1'b1;
                        state_r         <= S_START;
                    end
                    S_START: begin
                        state_r <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (calculate_done) begin
                            res_data  <= channel_out;
                            res_kidx  <= k_r;
                            res_valid <= 1'b1;
                            state_r   <= S_OUT;
                        end else begin
                            state_r <= S_WAIT;
                        end
                    end
                    S_OUT: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            if (k_r == K_LAST) begin
                                job_done <= 1'b1;
                                state_r  <= S_DONE;
                            end else begin
                                k_r     <= k_inc_s;
                                w_addr  <= k_inc_s;
                                w_rd_en <= 1'b1;
                                state_r <= S_FETCH;
                            end
                        end else begin
                            state_r <= S_OUT;
                        end
                    end
                    S_DONE: begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                    default: begin
                        k_r       <= '0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                        state_r   <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv2d_kernel_sched.sv
// Directed bench for conv2d_kernel_sched with a weight RAM and fixed-latency datapath model.
module tb_conv2d_kernel_sched;

    localparam int BW  = 8;
    localparam int FMN = 9;
    localparam int KS  = 9;
    localparam int FW  = FMN * KS * BW;
    localparam int WW  = KS * BW;
    localparam int RW  = BW * 2 * FMN;
    localparam int KW  = 2;
    localparam int LAT = 6;

    logic          clk, rst_n;
    logic          cmd_valid, cmd_ready, abort;
    logic [FW-1:0] cmd_fmaps, feature_maps;
    logic          w_rd_en;
    logic [KW-1:0] w_addr, res_kidx;
    logic [WW-1:0] w_rdata, weights;
    logic          calculate_start, calculate_done;
    logic [RW-1:0] channel_out, res_data;
    logic          res_valid, res_ready, busy, job_done;

    logic          cmd_valid1, cmd_ready1, abort1;
    logic [FW-1:0] cmd_fmaps1, feature_maps1;
    logic          w_rd_en1;
    logic [0:0]    w_addr1, res_kidx1;
    logic [WW-1:0] w_rdata1, weights1;
    logic          calculate_start1, done1;
    logic [RW-1:0] channel_out1, res_data1;
    logic          res_valid1, res_ready1, busy1, job_done1;

    logic [WW-1:0] wram [4];
    logic [2:0]    dp_cnt;
    logic          dp_pend, spur;

    int total = 0;
    int bad   = 0;

    int            nres, njd, jd_cyc, st_cyc, stall_bad, stall_rd, rdy_busy, timeout;
    logic          rdy_after;
    logic [KW-1:0] got_k [8];
    logic [RW-1:0] got_d [8];
    logic [FW-1:0] fm_seen;

    logic [FW-1:0] fm_a, fm_b, fm_c;

    conv2d_kernel_sched #(.KERNEL_TOTAL(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fmaps(cmd_fmaps), .abort(abort), .w_rd_en(w_rd_en), .w_addr(w_addr),
        .w_rdata(w_rdata), .feature_maps(feature_maps), .weights(weights),
        .calculate_start(calculate_start), .calculate_done(calculate_done),
        .channel_out(channel_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_kidx(res_kidx), .busy(busy), .job_done(job_done)
    );

    conv2d_kernel_sched #(.KERNEL_TOTAL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_fmaps(cmd_fmaps1), .abort(abort1), .w_rd_en(w_rd_en1), .w_addr(w_addr1),
        .w_rdata(w_rdata1), .feature_maps(feature_maps1), .weights(weights1),
        .calculate_start(calculate_start1), .calculate_done(done1),
        .channel_out(channel_out1), .res_valid(res_valid1), .res_ready(res_ready1),
        .res_data(res_data1), .res_kidx(res_kidx1), .busy(busy1), .job_done(job_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en)  w_rdata  <= wram[w_addr];
        if (w_rd_en1) w_rdata1 <= wram[w_addr1];
    end

    // Datapath model: done is raised in the LAT-th cycle after the start pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_pend <= 1'b0;
            dp_cnt  <= 3'd0;
        end else if (calculate_start) begin
            dp_pend <= 1'b1;
            dp_cnt  <= 3'(LAT - 1);
        end else if (dp_pend && dp_cnt == 3'd0) begin
            dp_pend <= 1'b0;
        end else if (dp_cnt != 3'd0) begin
            dp_cnt <= dp_cnt - 3'd1;
        end
    end

    assign calculate_done = (dp_pend && dp_cnt == 3'd0) || spur;
    assign channel_out    = {weights ^ feature_maps[WW-1:0], ~weights};
    assign channel_out1   = {weights1 ^ feature_maps1[WW-1:0], ~weights1};

    function automatic logic [RW-1:0] exp_res(input int k, input logic [FW-1:0] fm);
        return {wram[k] ^ fm[WW-1:0], ~wram[k]};
    endfunction

    // Drives one job from an IDLE negedge and records what the DUT did; ends on a negedge.
    task automatic run_job(input logic [FW-1:0] fm, input int stall_k, input int stall_n,
                           input bit hold_cmd, input int spur_at);
        int            stall;
        int            wait_n;
        bit            done_seen;
        logic [RW-1:0] snap_d;
        logic [KW-1:0] snap_k;
        nres = 0; njd = 0; jd_cyc = -1; st_cyc = -1; stall_bad = 0; stall_rd = 0;
        rdy_busy = 0; timeout = 0; stall = 0; done_seen = 1'b0;
        snap_d = '0; snap_k = '0;
        for (int i = 0; i < 8; i++) begin
            got_k[i] = 'x;
            got_d[i] = 'x;
        end
        cmd_fmaps = fm;
        cmd_valid = 1'b1;
        wait_n = 0;
        while (!cmd_ready && wait_n < 200) begin
            @(posedge clk); @(negedge clk);
            wait_n++;
        end
        @(posedge clk); @(negedge clk);
        if (!hold_cmd) cmd_valid = 1'b0;
        fm_seen = feature_maps;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            spur = (cyc == spur_at);
            if (cmd_ready) rdy_busy++;
            if (calculate_start && st_cyc < 0) st_cyc = cyc + 1;
            res_ready = 1'b0;
            if (res_valid) begin
                if (res_kidx == KW'(stall_k) && stall < stall_n) begin
                    if (stall == 0) begin
                        snap_d = res_data;
                        snap_k = res_kidx;
                    end else if (res_data !== snap_d || res_kidx !== snap_k) begin
                        stall_bad++;
                    end
                    if (w_rd_en) stall_rd++;
                    stall++;
                end else begin
                    res_ready = 1'b1;
                    if (nres < 8) begin
                        got_k[nres] = res_kidx;
                        got_d[nres] = res_data;
                    end
                    nres++;
                end
            end
            if (job_done) begin
                njd++;
                jd_cyc    = cyc + 1;
                done_seen = 1'b1;
            end
            @(posedge clk); @(negedge clk);
        end
        spur      = 1'b0;
        res_ready = 1'b0;
        if (!done_seen) timeout = 1;
        rdy_after = cmd_ready;
        if (job_done) njd++;
    endtask

    task automatic test_reset();
        total++;
        if ({cmd_ready, busy, res_valid, w_rd_en, calculate_start, job_done} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {cmd_ready, busy, res_valid, w_rd_en, calculate_start, job_done});
        end
        total++;
        if (feature_maps !== '0 || weights !== '0) begin
            bad++;
            $display("FAIL reset_fm_w: got fm=%h w=%h want zero", feature_maps, weights);
        end
        total++;
        if (res_data !== '0 || res_kidx !== '0 || w_addr !== '0) begin
            bad++;
            $display("FAIL reset_res: got data=%h kidx=%0d addr=%0d want zero", res_data, res_kidx, w_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic check_results(input string name, input logic [FW-1:0] fm, input int exp_jd);
        total++;
        if (timeout != 0 || nres != 4 || njd != 1) begin
            bad++;
            $display("FAIL %s_counts: got timeout=%0d nres=%0d njd=%0d want 0 4 1", name, timeout, nres, njd);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (got_k[k] !== KW'(k) || got_d[k] !== exp_res(k, fm)) begin
                bad++;
                $display("FAIL %s_res%0d: got kidx=%0d data=%h want kidx=%0d data=%h",
                         name, k, got_k[k], got_d[k], k, exp_res(k, fm));
            end
        end
        total++;
        if (jd_cyc != exp_jd) begin
            bad++;
            $display("FAIL %s_job_cycles: got %0d want %0d", name, jd_cyc, exp_jd);
        end
    endtask

    task automatic test_basic();
        run_job(fm_a, -1, 0, 1'b0, -1);
        check_results("basic", fm_a, 41);
        total++;
        if (st_cyc != 3) begin
            bad++;
            $display("FAIL basic_first_start: got cycle %0d want 3", st_cyc);
        end
        total++;
        if (fm_seen !== fm_a || rdy_after !== 1'b1 || rdy_busy != 0) begin
            bad++;
            $display("FAIL basic_fm_ready: got fm=%h ready_after=%b ready_busy=%0d want fm=%h 1 0",
                     fm_seen, rdy_after, rdy_busy, fm_a);
        end
        total++;
        if (weights !== wram[3] || feature_maps !== fm_a) begin
            bad++;
            $display("FAIL basic_hold: got w=%h want %h", weights, wram[3]);
        end
    endtask

    task automatic test_backpressure();
        run_job(fm_b, 1, 10, 1'b0, -1);
        check_results("bp", fm_b, 51);
        total++;
        if (stall_bad != 0 || stall_rd != 0) begin
            bad++;
            $display("FAIL bp_stall: got unstable=%0d rd_en=%0d want 0 0", stall_bad, stall_rd);
        end
    endtask

    task automatic test_cmd_busy();
        run_job(fm_a, -1, 0, 1'b1, -1);
        total++;
        if (rdy_busy != 0 || rdy_after !== 1'b1 || njd != 1) begin
            bad++;
            $display("FAIL busy_ready: got ready_busy=%0d ready_after=%b njd=%0d want 0 1 1",
                     rdy_busy, rdy_after, njd);
        end
        run_job(fm_c, -1, 0, 1'b0, -1);
        check_results("second", fm_c, 41);
        total++;
        if (fm_seen !== fm_c) begin
            bad++;
            $display("FAIL second_fm: got %h want %h", fm_seen, fm_c);
        end
    endtask

    task automatic test_abort();
        int nst;
        int seen_v;
        int seen_jd;
        int seen_busy;
        nst = 0;
        cmd_fmaps = fm_b;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 0; c < 200 && nst < 3; c++) begin
            if (calculate_start) nst++;
            @(posedge clk); @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        total++;
        if (nst != 3 || {busy, cmd_ready, res_valid, w_rd_en} !== 4'b0100) begin
            bad++;
            $display("FAIL abort_idle: got starts=%0d busy/ready/valid/rd=%b want 3 0100",
                     nst, {busy, cmd_ready, res_valid, w_rd_en});
        end
        seen_v = 0; seen_jd = 0; seen_busy = 0;
        for (int c = 0; c < 10; c++) begin
            if (res_valid) seen_v++;
            if (job_done) seen_jd++;
            if (busy) seen_busy++;
            @(posedge clk); @(negedge clk);
        end
        res_ready = 1'b0;
        total++;
        if (seen_v != 0 || seen_jd != 0 || seen_busy != 0 || res_data !== exp_res(1, fm_b)) begin
            bad++;
            $display("FAIL abort_late_done: got valid=%0d jd=%0d busy=%0d data=%h want 0 0 0 %h",
                     seen_v, seen_jd, seen_busy, res_data, exp_res(1, fm_b));
        end
        run_job(fm_a, -1, 0, 1'b0, -1);
        check_results("after_abort", fm_a, 41);
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        cmd_fmaps = fm_c;
        cmd_valid = 1'b1;
        res_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        while (!res_valid && n < 50) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL arst_reach_out: got res_valid=%b want 1", res_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cmd_ready, busy, res_valid, w_rd_en, calculate_start, job_done} !== 6'b100000) begin
            bad++;
            $display("FAIL arst_ctrl: got %b want 100000",
                     {cmd_ready, busy, res_valid, w_rd_en, calculate_start, job_done});
        end
        total++;
        if (feature_maps !== '0 || weights !== '0 || res_data !== '0 || res_kidx !== '0) begin
            bad++;
            $display("FAIL arst_data: got data=%h kidx=%0d w=%h want zero", res_data, res_kidx, weights);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_release: got ready=%b busy=%b valid=%b want 1 0 0", cmd_ready, busy, res_valid);
        end
    endtask

    task automatic test_spurious();
        spur = 1'b1;
        @(posedge clk); @(negedge clk);
        spur = 1'b0;
        @(posedge clk); @(negedge clk);
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== '0) begin
            bad++;
            $display("FAIL spur_idle: got valid=%b busy=%b data=%h want 0 0 0", res_valid, busy, res_data);
        end
        run_job(fm_b, -1, 0, 1'b0, 0);
        check_results("spur_fetch", fm_b, 41);
    endtask

    task automatic test_single_kernel();
        int            st1, n1, j1;
        logic [0:0]    k1;
        logic [RW-1:0] d1;
        st1 = -1; n1 = 0; j1 = 0; k1 = 'x; d1 = 'x;
        done1 = 1'b1;
        @(posedge clk); @(negedge clk);
        done1 = 1'b0;
        total++;
        if (res_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL k1_spur_idle: got valid=%b busy=%b want 0 0", res_valid1, busy1);
        end
        cmd_fmaps1 = fm_c;
        cmd_valid1 = 1'b1;
        res_ready1 = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_valid1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            done1 = (c == 0) || (st1 >= 0 && c == st1 + 2);
            if (calculate_start1 && st1 < 0) st1 = c;
            if (res_valid1) begin
                n1++;
                k1 = res_kidx1;
                d1 = res_data1;
            end
            if (job_done1) j1++;
            @(posedge clk); @(negedge clk);
        end
        done1 = 1'b0;
        total++;
        if (n1 != 1 || j1 != 1 || k1 !== 1'b0 || d1 !== exp_res(0, fm_c)) begin
            bad++;
            $display("FAIL k1_job: got nres=%0d njd=%0d kidx=%b data=%h want 1 1 0 %h",
                     n1, j1, k1, d1, exp_res(0, fm_c));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_fmaps = '0; abort = 1'b0; res_ready = 1'b0; spur = 1'b0;
        cmd_valid1 = 1'b0; cmd_fmaps1 = '0; abort1 = 1'b0; res_ready1 = 1'b0; done1 = 1'b0;
        wram[0] = 72'h00_11_22_33_44_55_66_77_88;
        wram[1] = 72'h9A_BC_DE_F0_12_34_56_78_9A;
        wram[2] = 72'hFE_DC_BA_98_76_54_32_10_0F;
        wram[3] = 72'h5A_A5_3C_C3_69_96_E1_1E_77;
        fm_a = {81{8'h5A}};
        fm_b = {81{8'hC3}};
        fm_c = {72{9'h1A5}};
        #12;
        test_reset();
        test_basic();
        test_backpressure();
        test_cmd_busy();
        test_abort();
        test_async_reset();
        test_spurious();
        test_single_kernel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
